fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word requests to instruction memory, tracks
// in-flight responses, and presents fetched instructions in order to IF/ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_f,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_f,
    output logic [31:0] instr_f,
    output logic [31:0] pc_next_f,
    output logic        valid_f
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  out_cnt_q, out_cnt_d;
    logic [1:0]  disc_cnt_q, disc_cnt_d;
    logic [1:0]  buf_cnt_q, buf_cnt_d;
    logic        buf_rd_q, buf_rd_d;
    logic        buf_wr_q, buf_wr_d;
    logic        pcf_rd_q, pcf_rd_d;
    logic        pcf_wr_q, pcf_wr_d;

    logic [31:0] buf_pc_q [2];
    logic [31:0] buf_pc_d [2];
    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_instr_d [2];
    logic [31:0] pcf_q [2];
    logic [31:0] pcf_d [2];

    logic [31:0] redirect_pc;
    logic [31:0] head_pc;
    logic [2:0]  inflight;
    logic [2:0]  occupancy;
    logic        pop;
    logic        issue;
    logic        resp;
    logic        drop;
    logic        push;

    assign redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;
    assign head_pc     = buf_pc_q[buf_rd_q];

    assign valid_f   = (buf_cnt_q != 2'd0);
    assign pc_f      = valid_f ? head_pc : 32'h0000_0000;
    assign instr_f   = valid_f ? buf_instr_q[buf_rd_q] : NOP_INSTR;
    assign pc_next_f = valid_f ? head_pc + 32'd4 : 32'h0000_0000;

    assign pop = valid_f & ~stall_f;

    // Requests are limited so every granted fetch already owns a buffer slot.
    assign inflight   = {1'b0, out_cnt_q} + {1'b0, disc_cnt_q};
    assign occupancy  = {1'b0, out_cnt_q} + {1'b0, buf_cnt_q} - {2'b00, pop};
    assign imem_req_o = ~rst_i & (inflight < 3'd2) & (occupancy < 3'd2);
    assign imem_addr_o = redirect_i ? redirect_pc : fetch_pc_q;

    assign issue = imem_req_o & imem_gnt_i;
    assign resp  = imem_rvalid_i & (inflight != 3'd0);
    assign drop  = resp & (disc_cnt_q != 2'd0);
    assign push  = resp & (disc_cnt_q == 2'd0) & ~redirect_i;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        out_cnt_d   = out_cnt_q;
        disc_cnt_d  = disc_cnt_q;
        buf_cnt_d   = buf_cnt_q;
        buf_rd_d    = buf_rd_q;
        buf_wr_d    = buf_wr_q;
        pcf_rd_d    = pcf_rd_q;
        pcf_wr_d    = pcf_wr_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        pcf_d       = pcf_q;

        if (issue) begin
            pcf_d[pcf_wr_q] = imem_addr_o;
            pcf_wr_d        = ~pcf_wr_q;
            fetch_pc_d      = imem_addr_o + 32'd4;
        end else if (redirect_i) begin
            fetch_pc_d = redirect_pc;
        end

        if (resp) begin
            pcf_rd_d = ~pcf_rd_q;
        end

        if (redirect_i) begin
            // Everything still in flight becomes stale; a response consumed now is already gone.
            disc_cnt_d = out_cnt_q + disc_cnt_q - {1'b0, resp};
            out_cnt_d  = {1'b0, issue};
            buf_cnt_d  = 2'd0;
            buf_rd_d   = 1'b0;
            buf_wr_d   = 1'b0;
        end else begin
            disc_cnt_d = disc_cnt_q - {1'b0, drop};
            out_cnt_d  = out_cnt_q + {1'b0, issue} - {1'b0, push};
            if (push) begin
                buf_pc_d[buf_wr_q]    = pcf_q[pcf_rd_q];
                buf_instr_d[buf_wr_q] = imem_rdata_i;
                buf_wr_d              = ~buf_wr_q;
            end
            if (pop) begin
                buf_rd_d = ~buf_rd_q;
            end
            buf_cnt_d = buf_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            out_cnt_q  <= 2'd0;
            disc_cnt_q <= 2'd0;
            buf_cnt_q  <= 2'd0;
            buf_rd_q   <= 1'b0;
            buf_wr_q   <= 1'b0;
            pcf_rd_q   <= 1'b0;
            pcf_wr_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_cnt_q  <= out_cnt_d;
            disc_cnt_q <= disc_cnt_d;
            buf_cnt_q  <= buf_cnt_d;
            buf_rd_q   <= buf_rd_d;
            buf_wr_q   <= buf_wr_d;
            pcf_rd_q   <= pcf_rd_d;
            pcf_wr_q   <= pcf_wr_d;
        end
    end

    // Storage arrays carry no reset; the counters decide what is meaningful.
    always_ff @(posedge clk_i) begin
        buf_pc_q    <= buf_pc_d;
        buf_instr_q <= buf_instr_d;
        pcf_q       <= pcf_d;
    end

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && buf_cnt_q == 2'd2));

    a_inflight_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
        inflight <= 3'd2);

    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (rst_i)
        !(imem_rvalid_i && inflight == 3'd0));

    a_addr_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (imem_req_o && !imem_gnt_i && !redirect_i) |=>
        (redirect_i || imem_addr_o == $past(imem_addr_o)));

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: an in-order memory model answers requests,
// and each instruction handed to IF/ID is matched against the expected stream.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_f;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_f;
    logic [31:0] instr_f;
    logic [31:0] pc_next_f;
    logic        valid_f;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_f(stall_f),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i),
        .pc_f(pc_f), .instr_f(instr_f), .pc_next_f(pc_next_f), .valid_f(valid_f)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] pc; logic [31:0] instr; logic [31:0] pcn; } exp_t;
    typedef struct { logic [31:0] addr; int rdy; } mreq_t;

    exp_t  sb_q[$];
    mreq_t mem_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    lat = 1;
    logic  gnt_en = 1'b1;
    int    first_pop_cyc = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[17:2], a[17:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_run(input logic [31:0] start, input int n);
        exp_t e;
        logic [31:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            e.pc    = pc;
            e.instr = mem_word(pc);
            e.pcn   = pc + 32'd4;
            sb_q.push_back(e);
            pc = pc + 32'd4;
        end
    endtask

    // One clock: drive memory, sample at negedge+1, score, advance to next negedge.
    task automatic step();
        exp_t  e;
        mreq_t m;
        imem_gnt_i = gnt_en;
        if (rst_i) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hDEAD_BEEF;
        end else if (mem_q.size() != 0 && mem_q[0].rdy <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mem_q[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0000_0000;
        end
        #1;
        if (!rst_i) begin
            if (valid_f && !stall_f && !redirect_i) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_instr", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("pc_f", pc_f, e.pc);
                    chk("instr_f", instr_f, e.instr);
                    chk("pc_next_f", pc_next_f, e.pcn);
                    if (first_pop_cyc < 0) first_pop_cyc = cyc;
                end
            end
            if (imem_rvalid_i && mem_q.size() != 0) void'(mem_q.pop_front());
            if (imem_req_o && imem_gnt_i) begin
                m.addr = imem_addr_o;
                m.rdy  = cyc + lat;
                mem_q.push_back(m);
            end
        end
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        stall_f = 1'b0;
        while (sb_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        stall_f = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        sb_q.delete();
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        step();
        redirect_i    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; stall_f = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        @(negedge clk_i);
        step(); step();
        #1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(valid_f), 32'd0);
        chk("rst_instr", instr_f, NOP);
        chk("rst_pc", pc_f, 32'h0);
        chk("rst_pcn", pc_next_f, 32'h0);
        step();

        // Reset release: stream from RESET_PC at one instruction per cycle.
        rst_i = 1'b0; mem_q.delete(); cyc = 0;
        #1;
        chk("rel_req", 32'(imem_req_o), 32'd1);
        chk("rel_addr", imem_addr_o, RST_PC);
        expect_run(RST_PC, 2);
        drain(40);
        chk("first_valid_cyc", 32'(first_pop_cyc), 32'd2);
        chk("stream_cycles", 32'(cyc), 32'd4);

        // Stall with head at 0x8: outputs hold, requests stop once full.
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", 32'(valid_f), 32'd1);
            chk("stall_pc", pc_f, 32'h8);
            chk("stall_instr", instr_f, mem_word(32'h8));
            chk("stall_req", 32'(imem_req_o), 32'd0);
            step();
        end
        lat = 3;
        expect_run(32'h8, 2);
        drain(40);

        // Redirect with 0x10 and 0x14 still outstanding.
        #1;
        chk("pre_redir_req", 32'(imem_req_o), 32'd0);
        redirect_to(32'h0000_0100);
        #1;
        chk("post_redir_valid", 32'(valid_f), 32'd0);
        expect_run(32'h100, 3);
        drain(60);

        // Settle with a full buffer, then redirect while grants are withheld.
        lat = 1;
        for (int i = 0; i < 8; i++) step();
        gnt_en = 1'b0;
        redirect_to(32'h0000_0200);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nognt_req", 32'(imem_req_o), 32'd1);
            chk("nognt_addr", imem_addr_o, 32'h200);
            step();
        end
        gnt_en = 1'b1;
        expect_run(32'h200, 3);
        drain(40);

        // Redirect to the top word (low bits ignored) while a request is granted.
        stall_f = 1'b0;
        sb_q.delete();
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        #1;
        chk("redir_req", 32'(imem_req_o), 32'd1);
        chk("redir_addr", imem_addr_o, 32'hFFFF_FFFC);
        step();
        redirect_i = 1'b0;
        #1;
        chk("wrap_valid0", 32'(valid_f), 32'd0);
        expect_run(32'hFFFF_FFFC, 3);
        drain(40);

        // Reset in the middle of traffic.
        lat = 3;
        step();
        rst_i = 1'b1;
        #1;
        chk("mid_rst_req", 32'(imem_req_o), 32'd0);
        step();
        #1;
        chk("mid_rst_valid", 32'(valid_f), 32'd0);
        chk("mid_rst_instr", instr_f, NOP);
        step();
        rst_i = 1'b0; mem_q.delete(); sb_q.delete(); lat = 1;
        #1;
        chk("mid_rel_req", 32'(imem_req_o), 32'd1);
        chk("mid_rel_addr", imem_addr_o, RST_PC);
        expect_run(RST_PC, 3);
        drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
